// File: rtl/buffer_fill_ctrl_if.sv
// Byte-stream handshake into the fill controller and the lane/read-address
// bus it drives into the 4-lane buffer.
//   in_data/in_valid/in_ready : upstream valid/ready byte stream
//   data_out_0..3             : held lane values, buffer data_in_0..3
//   buffer_read_addr_out      : buffer read address
//   out_valid/frame_done      : buffer data_out valid strobe, last-byte pulse
// master = the fill controller, slave = the byte source / buffer side.
interface buffer_fill_ctrl_if #(
  parameter int DATA_W = 8
);
  logic [DATA_W-1:0] in_data;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] data_out_0;
  logic [DATA_W-1:0] data_out_1;
  logic [DATA_W-1:0] data_out_2;
  logic [DATA_W-1:0] data_out_3;
  logic [1:0]        buffer_read_addr_out;
  logic              out_valid;
  logic              frame_done;

  modport master (
    input  in_data, in_valid,
    output in_ready, data_out_0, data_out_1, data_out_2, data_out_3,
    output buffer_read_addr_out, out_valid, frame_done
  );

  modport slave (
    output in_data, in_valid,
    input  in_ready, data_out_0, data_out_1, data_out_2, data_out_3,
    input  buffer_read_addr_out, out_valid, frame_done
  );
endinterface

// File: rtl/buffer_fill_ctrl.sv
// Upstream stage of the 4-lane buffer: packs four accepted bytes into lanes
// 0..3, holds them one SETTLE cycle so the buffer registers capture them,
// then sweeps the buffer read address 0..3 with out_valid aligned to the
// buffer's combinational data output.
// Ports:
//   clk  : rising-edge clock
//   rst  : synchronous active-high reset
//   bus  : buffer_fill_ctrl_if master (byte handshake in, lanes/addr/strobes out)
module buffer_fill_ctrl #(
  parameter int DATA_W = 8,
  parameter int LANES  = 4
) (
  input  logic                clk,
  input  logic                rst,
  buffer_fill_ctrl_if.master  bus
);

  typedef enum logic [1:0] {
    FILL   = 2'd0,
    SETTLE = 2'd1,
    DRAIN  = 2'd2
  } state_t;

  localparam logic [1:0] LAST = 2'(LANES - 1);

  state_t            state_q;
  logic [1:0]        wr_cnt_q;
  logic [1:0]        rd_cnt_q;
  logic [1:0]        addr_q;
  logic [DATA_W-1:0] lane_q [LANES];
  logic              out_valid_q;
  logic              frame_done_q;
  logic              accept;

  assign bus.in_ready = (state_q == FILL) && !rst;
  assign accept       = bus.in_valid && bus.in_ready;

  assign bus.data_out_0           = lane_q[0];
  assign bus.data_out_1           = lane_q[1];
  assign bus.data_out_2           = lane_q[2];
  assign bus.data_out_3           = lane_q[3];
  assign bus.buffer_read_addr_out = addr_q;
  assign bus.out_valid            = out_valid_q;
  assign bus.frame_done           = frame_done_q;

  // Strobes and address are registered one state ahead so they line up with
  // the DRAIN cycles; addr_q tracks rd_cnt_q in DRAIN and holds afterwards.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= FILL;
      wr_cnt_q     <= '0;
      rd_cnt_q     <= '0;
      addr_q       <= '0;
      out_valid_q  <= 1'b0;
      frame_done_q <= 1'b0;
      for (int unsigned i = 0; i < LANES; i++) lane_q[i] <= '0;
    end else begin
      case (state_q)
        FILL: begin
          if (accept) begin
            lane_q[wr_cnt_q] <= bus.in_data;
            if (wr_cnt_q == LAST) begin
              wr_cnt_q <= '0;
              state_q  <= SETTLE;
            end else begin
              wr_cnt_q <= wr_cnt_q + 2'd1;
            end
          end
        end
        SETTLE: begin
          state_q      <= DRAIN;
          rd_cnt_q     <= '0;
          addr_q       <= '0;
          out_valid_q  <= 1'b1;
          frame_done_q <= 1'b0;
        end
        DRAIN: begin
          if (rd_cnt_q == LAST) begin
            state_q      <= FILL;
            rd_cnt_q     <= '0;
            out_valid_q  <= 1'b0;
            frame_done_q <= 1'b0;
          end else begin
            rd_cnt_q     <= rd_cnt_q + 2'd1;
            addr_q       <= rd_cnt_q + 2'd1;
            frame_done_q <= (rd_cnt_q == LAST - 2'd1);
          end
        end
        default: state_q <= FILL;
      endcase
    end
  end

endmodule

// File: doc/buffer_fill_ctrl.md
Name: buffer_fill_ctrl

Overview:
Upstream stage of the 4-lane 8-bit buffer. Accepts a byte stream over a valid/ready handshake and packs four consecutive bytes into lanes 0..3. It holds the lanes stable on the buffer's data inputs, waits one cycle for the buffer registers to capture them, then sweeps the buffer read address 0..3. A valid strobe is aligned to the buffer's data output.

Parameters:
DATA_W, 8, width of each byte/lane; must match the buffer lane width.
LANES, 4, lanes per frame; fixed at 4, matching the 2-bit buffer read address.

Ports:
clk  input  1  clock; all state updates on rising edge
rst  input  1  reset, synchronous, active-high
in_data  input  DATA_W  incoming byte
in_valid  input  1  in_data is valid this cycle
in_ready  output  1  block can accept a byte this cycle
data_out_0  output  DATA_W  lane 0 hold value, drives buffer data_in_0
data_out_1  output  DATA_W  lane 1 hold value, drives buffer data_in_1
data_out_2  output  DATA_W  lane 2 hold value, drives buffer data_in_2
data_out_3  output  DATA_W  lane 3 hold value, drives buffer data_in_3
buffer_read_addr_out  output  2  drives buffer read address
out_valid  output  1  buffer data_out is a valid frame byte this cycle
frame_done  output  1  one-cycle pulse on the last drain cycle of a frame

Behaviour:
- Reset is synchronous, active-high, and acts on the clock edge.
  - State goes to FILL.
  - wr_cnt=0, rd_cnt=0.
  - data_out_0..3=0, buffer_read_addr_out=0, out_valid=0, frame_done=0.
  - in_ready=0 while rst=1.
- Reset mid-FILL or mid-DRAIN aborts the frame. Partial bytes are discarded and no frame_done is issued.
- Accept occurs when in_valid && in_ready on a clock edge.
- in_ready=1 only in FILL (combinational from state, gated by rst). in_ready is never high in SETTLE or DRAIN.
- FILL:
  - On each accept: lane[wr_cnt] <= in_data, then wr_cnt++.
  - Bytes land in lane order 0,1,2,3.
  - in_valid=0 leaves all state unchanged; gaps between bytes are unlimited.
  - On the accept with wr_cnt==3: wr_cnt <= 0 and state goes to SETTLE.
- SETTLE:
  - Lasts exactly one cycle; the buffer registers capture the held lanes.
  - out_valid=0. Next state is DRAIN with rd_cnt=0.
- DRAIN:
  - buffer_read_addr_out=rd_cnt, out_valid=1, and rd_cnt increments each cycle.
  - The buffer output is combinational off its registers, so lane k appears in the same cycle as addr k.
  - When rd_cnt==3: frame_done=1 for that cycle; the next state is FILL and rd_cnt goes to 0.
- Outside DRAIN, out_valid=0 and frame_done=0. buffer_read_addr_out holds its last value (0 after reset).
- Lane registers change only on accepts in FILL. They are stable throughout SETTLE and DRAIN, because the buffer samples every clock with no enable.
- Timing when the 4th byte is accepted at the end of cycle n:
  - SETTLE occupies cycle n+1.
  - DRAIN occupies cycles n+2..n+5, carrying addr 0,1,2,3.
  - in_ready=1 again from cycle n+6.
- Minimum frame period is 9 cycles (4 fill + 1 settle + 4 drain).
- in_valid asserted during SETTLE or DRAIN is ignored; the source must hold it until in_ready=1. A byte is never dropped or duplicated.
- There are no arithmetic overflow cases. Counters are 2 bits and wrap 3→0 only at the transitions above.

Test Plan:
1. Reset check: hold rst for 2 cycles with in_valid=1 -> in_ready=0, data_out_0..3=0x00, out_valid=0, addr=0. Release -> in_ready=1 on the next cycle.
2. Back-to-back frame: send 0x11,0x22,0x33,0x44 in consecutive cycles.
   - data_out_0..3=0x11/0x22/0x33/0x44.
   - One SETTLE cycle follows, then out_valid=1 for 4 cycles with addr 0,1,2,3 and buffer data_out 0x11,0x22,0x33,0x44.
   - frame_done is high only with addr=3.
3. Gapped input: send 0xA0,_,_,0xA1,_,0xA2,0xA3 (_ = in_valid low) -> lanes are A0..A3 in order. No DRAIN starts before the 4th accept.
4. Backpressure: hold in_valid=1 with data 0x55 during SETTLE/DRAIN -> in_ready=0 and the lanes stay unchanged. 0x55 is accepted into lane 0 on the first FILL cycle after frame_done.
5. Reset mid-DRAIN: assert rst at the addr=1 cycle -> on the next cycle out_valid=0, frame_done never pulses, and the lanes are 0. A following frame 0x01..0x04 drains correctly.
6. Two consecutive frames 0x10..0x13 then 0x20..0x23 with the source always valid -> a 9-cycle period and the second drain outputs 0x20..0x23 exactly.
